// File: rtl/soma_pkg.sv
// Shared types and constants for the uc_soma float-add control unit.
// SHIFT_SAT is the alignment distance beyond which every mantissa bit shifts out.
package soma_pkg;

    localparam int unsigned N_EXP     = 8;
    localparam int unsigned N_MANT    = 23;
    localparam int unsigned SHIFT_SAT = N_MANT + 2;

    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StAdd,
        StNorm,
        StRound,
        StRenorm,
        StDone
    } state_e;

endpackage

// File: rtl/uc_soma_if.sv
// Control/status bundle between the uc_soma FSM and the float-add datapath.
// The master side is the datapath (drives status), the slave side is the controller.
interface uc_soma_if import soma_pkg::*; #(
    parameter int unsigned N_exp = N_EXP
);

    logic             start;
    logic [N_exp-1:0] diferenca_exp;
    logic             exp_A_ge_B;
    logic             sum_carry;
    logic [N_exp-1:0] lead_zeros;
    logic             sum_zero;
    logic             lsb;
    logic             guard;
    logic             sticky;
    logic             round_carry;

    logic             BigAlu_in_A;
    logic             BigAlu_in_B;
    logic [N_exp-1:0] ShiftDif_amount;
    logic             Exp_sel;
    logic             ShiftNorm_sel;
    logic [N_exp-1:0] ShiftNorm_amount;
    logic             Increment_sel;
    logic [N_exp-1:0] Increment_amount;
    logic             Round_amount;
    logic             busy;
    logic             done;
    logic             result_zero;

    modport master (
        output start, diferenca_exp, exp_A_ge_B, sum_carry, lead_zeros, sum_zero,
               lsb, guard, sticky, round_carry,
        input  BigAlu_in_A, BigAlu_in_B, ShiftDif_amount, Exp_sel, ShiftNorm_sel,
               ShiftNorm_amount, Increment_sel, Increment_amount, Round_amount,
               busy, done, result_zero
    );

    modport slave (
        input  start, diferenca_exp, exp_A_ge_B, sum_carry, lead_zeros, sum_zero,
               lsb, guard, sticky, round_carry,
        output BigAlu_in_A, BigAlu_in_B, ShiftDif_amount, Exp_sel, ShiftNorm_sel,
               ShiftNorm_amount, Increment_sel, Increment_amount, Round_amount,
               busy, done, result_zero
    );

endinterface

// File: rtl/soma_dif_mag.sv
// Turns the small-ALU exponent difference into an operand swap flag and a
// saturated alignment shift magnitude.
module soma_dif_mag import soma_pkg::*; #(
    parameter int unsigned NExp     = N_EXP,
    parameter int unsigned ShiftSat = SHIFT_SAT
) (
    input  logic [NExp-1:0] diff_i,
    input  logic            a_ge_b_i,
    output logic            swap_o,
    output logic [NExp-1:0] amount_o
);

    logic [NExp-1:0] mag;

    always_comb begin
        swap_o   = ~a_ge_b_i;
        mag      = a_ge_b_i ? diff_i : (~diff_i + NExp'(1));
        amount_o = (mag > NExp'(ShiftSat)) ? NExp'(ShiftSat) : mag;
    end

endmodule

// File: rtl/uc_soma.sv
// Moore control FSM for the float adder: align, add, normalize, round, renormalize.
// Define SOMA_ROUND_EN for round-to-nearest-even; otherwise results are truncated.
module uc_soma import soma_pkg::*; #(
    parameter int unsigned N_float = 32,
    parameter int unsigned N_exp   = N_EXP,
    parameter int unsigned N_mant  = N_MANT
) (
    input logic     clk,
    input logic     rst_n,
    uc_soma_if.slave bus
);

    state_e           state_q, state_d;
    logic             swap;
    logic [N_exp-1:0] shamt;

    logic             big_a_q, big_a_d, big_b_q, big_b_d, exp_sel_q, exp_sel_d;
    logic [N_exp-1:0] shift_dif_q, shift_dif_d;
    logic             norm_sel_q, norm_sel_d, inc_sel_q, inc_sel_d;
    logic [N_exp-1:0] norm_amt_q, norm_amt_d, inc_amt_q, inc_amt_d;
    logic             round_q, round_d, busy_q, busy_d, done_q, done_d, zero_q, zero_d;

    logic [N_float-1:0] unused_float_w;
    assign unused_float_w = '0;

    soma_dif_mag #(
        .NExp     (N_exp),
        .ShiftSat (N_mant + 2)
    ) u_dif_mag (
        .diff_i   (bus.diferenca_exp),
        .a_ge_b_i (bus.exp_A_ge_B),
        .swap_o   (swap),
        .amount_o (shamt)
    );

    always_comb begin
        state_d     = state_q;
        big_a_d     = big_a_q;
        big_b_d     = big_b_q;
        exp_sel_d   = exp_sel_q;
        shift_dif_d = shift_dif_q;
        norm_sel_d  = 1'b0;
        norm_amt_d  = '0;
        inc_sel_d   = 1'b0;
        inc_amt_d   = '0;
        round_d     = 1'b0;
        done_d      = 1'b0;
        zero_d      = zero_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d     = StAlign;
                    big_a_d     = swap;
                    big_b_d     = ~swap;
                    exp_sel_d   = swap;
                    shift_dif_d = shamt;
                    zero_d      = 1'b0;
                end
            end
            StAlign: state_d = StAdd;
            StAdd:   state_d = StNorm;
            StNorm: begin
                if (bus.sum_zero) begin
                    zero_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    if (bus.sum_carry) begin
                        norm_amt_d = N_exp'(1);
                        inc_amt_d  = N_exp'(1);
                    end else begin
                        norm_sel_d = 1'b1;
                        norm_amt_d = bus.lead_zeros;
                        inc_sel_d  = 1'b1;
                        inc_amt_d  = bus.lead_zeros;
                    end
`ifdef SOMA_ROUND_EN
                    state_d = StRound;
`else
                    state_d = StDone;
`endif
                end
            end
            StRound: begin
`ifdef SOMA_ROUND_EN
                round_d = bus.guard & (bus.sticky | bus.lsb);
                state_d = bus.round_carry ? StRenorm : StDone;
`else
                state_d = StDone;
`endif
            end
            StRenorm: begin
                // Rounding overflowed the mantissa: shift right once, bump exponent.
                norm_amt_d = N_exp'(1);
                inc_amt_d  = N_exp'(1);
                state_d    = StDone;
            end
            StDone: begin
                done_d      = 1'b1;
                state_d     = StIdle;
                big_a_d     = 1'b0;
                big_b_d     = 1'b0;
                exp_sel_d   = 1'b0;
                shift_dif_d = '0;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

`ifndef SOMA_ROUND_EN
    logic unused_round;
    assign unused_round = ^{bus.lsb, bus.guard, bus.sticky, bus.round_carry};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            big_a_q     <= 1'b0;
            big_b_q     <= 1'b0;
            exp_sel_q   <= 1'b0;
            shift_dif_q <= '0;
            norm_sel_q  <= 1'b0;
            norm_amt_q  <= '0;
            inc_sel_q   <= 1'b0;
            inc_amt_q   <= '0;
            round_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            big_a_q     <= big_a_d;
            big_b_q     <= big_b_d;
            exp_sel_q   <= exp_sel_d;
            shift_dif_q <= shift_dif_d;
            norm_sel_q  <= norm_sel_d;
            norm_amt_q  <= norm_amt_d;
            inc_sel_q   <= inc_sel_d;
            inc_amt_q   <= inc_amt_d;
            round_q     <= round_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.BigAlu_in_A      = big_a_q;
    assign bus.BigAlu_in_B      = big_b_q;
    assign bus.Exp_sel          = exp_sel_q;
    assign bus.ShiftDif_amount  = shift_dif_q;
    assign bus.ShiftNorm_sel    = norm_sel_q;
    assign bus.ShiftNorm_amount = norm_amt_q;
    assign bus.Increment_sel    = inc_sel_q;
    assign bus.Increment_amount = inc_amt_q;
    assign bus.Round_amount     = round_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.result_zero      = zero_q;

endmodule

// File: tb/tb_uc_soma.sv
// Self-checking bench for uc_soma: directed and random operations scored
// against a latency/behaviour model derived from the operation rules.
module tb_uc_soma;

`ifdef SOMA_ROUND_EN
    localparam bit RoundEn = 1'b1;
`else
    localparam bit RoundEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    uc_soma_if #(.N_exp(8)) bus ();

    uc_soma dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] all_outs();
        return {bus.BigAlu_in_A, bus.BigAlu_in_B, bus.ShiftDif_amount, bus.Exp_sel,
                bus.ShiftNorm_sel, bus.ShiftNorm_amount, bus.Increment_sel,
                bus.Increment_amount, bus.Round_amount, bus.busy, bus.done, bus.result_zero};
    endfunction

    task automatic idle_inputs();
        bus.start = 1'b0; bus.diferenca_exp = '0; bus.exp_A_ge_B = 1'b0;
        bus.sum_carry = 1'b0; bus.lead_zeros = '0; bus.sum_zero = 1'b0;
        bus.lsb = 1'b0; bus.guard = 1'b0; bus.sticky = 1'b0; bus.round_carry = 1'b0;
    endtask

    // One full operation; datapath status is held constant for its duration.
    task automatic run_op(input logic [7:0] d, input logic ge, input logic carry,
                          input logic [7:0] lz, input logic zero, input logic l,
                          input logic g, input logic s, input logic rc,
                          input bit poke_done, input string tag);
        int mag, shift, lat, done_at, done_cnt, nev, rcnt, exp_nev;
        bit exp_swap, exp_renorm, exp_round;
        logic [17:0] ev1, ev2, exp_ev1, cur_ev;
        mag        = ge ? int'(d) : (256 - int'(d)) % 256;
        shift      = (mag > 25) ? 25 : mag;
        exp_swap   = !ge;
        exp_renorm = RoundEn && !zero && rc;
        exp_round  = RoundEn && !zero && g && (s || l);
        lat        = (zero || !RoundEn) ? 4 : (rc ? 6 : 5);
        exp_nev    = zero ? 0 : (exp_renorm ? 2 : 1);
        exp_ev1    = carry ? {1'b0, 8'd1, 1'b0, 8'd1} : {1'b1, lz, 1'b1, lz};
        done_at = -1; done_cnt = 0; nev = 0; rcnt = 0; ev1 = '0; ev2 = '0;

        @(negedge clk);
        bus.diferenca_exp = d; bus.exp_A_ge_B = ge; bus.sum_carry = carry;
        bus.lead_zeros = lz; bus.sum_zero = zero; bus.lsb = l; bus.guard = g;
        bus.sticky = s; bus.round_carry = rc; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int n = 0; n <= lat + 2; n++) begin
            @(negedge clk);
            if (n == 0) begin
                checks++;
                if ({bus.busy, bus.BigAlu_in_A, bus.BigAlu_in_B, bus.Exp_sel, bus.result_zero}
                    !== {1'b1, exp_swap, !exp_swap, exp_swap, 1'b0}) begin
                    errors++;
                    $display("FAIL %s align_ctrl: got busy/A/B/sel/zero=%b%b%b%b%b want %b%b%b%b0",
                             tag, bus.busy, bus.BigAlu_in_A, bus.BigAlu_in_B, bus.Exp_sel,
                             bus.result_zero, 1'b1, exp_swap, !exp_swap, exp_swap);
                end
                checks++;
                if (bus.ShiftDif_amount !== 8'(shift)) begin
                    errors++;
                    $display("FAIL %s shift_dif: got %0d want %0d", tag, bus.ShiftDif_amount, shift);
                end
            end
            if (n == lat - 1) begin
                checks++;
                if ({bus.busy, bus.ShiftDif_amount, bus.BigAlu_in_A} !== {1'b1, 8'(shift), exp_swap}) begin
                    errors++;
                    $display("FAIL %s hold_in_done: got busy=%b shift=%0d A=%b want 1 %0d %b",
                             tag, bus.busy, bus.ShiftDif_amount, bus.BigAlu_in_A, shift, exp_swap);
                end
            end
            if (n == lat || (poke_done && n == lat + 1)) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_after_done(n=%0d): got %b want 0", tag, n, bus.busy);
                end
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (bus.Round_amount === 1'b1) rcnt++;
            cur_ev = {bus.ShiftNorm_sel, bus.ShiftNorm_amount, bus.Increment_sel, bus.Increment_amount};
            if (cur_ev != '0) begin
                nev++;
                if (nev == 1) ev1 = cur_ev;
                else if (nev == 2) ev2 = cur_ev;
            end
            if (poke_done && n == lat - 1) bus.start = 1'b1;
            if (poke_done && n == lat) bus.start = 1'b0;
            @(posedge clk);
        end

        checks++;
        if (done_cnt != 1 || done_at != lat) begin
            errors++;
            $display("FAIL %s done_latency: got %0d pulses at %0d want 1 at %0d",
                     tag, done_cnt, done_at, lat);
        end
        checks++;
        if (nev != exp_nev) begin
            errors++;
            $display("FAIL %s norm_events: got %0d want %0d", tag, nev, exp_nev);
        end
        if (!zero) begin
            checks++;
            if (ev1 !== exp_ev1) begin
                errors++;
                $display("FAIL %s norm_ctrl: got %h want %h", tag, ev1, exp_ev1);
            end
        end
        if (exp_renorm) begin
            checks++;
            if (ev2 !== {1'b0, 8'd1, 1'b0, 8'd1}) begin
                errors++;
                $display("FAIL %s renorm_ctrl: got %h want %h", tag, ev2, {1'b0, 8'd1, 1'b0, 8'd1});
            end
        end
        checks++;
        if (rcnt != (exp_round ? 1 : 0)) begin
            errors++;
            $display("FAIL %s round_amount: got %0d cycles want %0d", tag, rcnt, exp_round ? 1 : 0);
        end
        checks++;
        if (bus.result_zero !== zero) begin
            errors++;
            $display("FAIL %s result_zero: got %b want %b", tag, bus.result_zero, zero);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        #12;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h want 0", all_outs());
        end
    endtask

    task automatic test_directed();
        run_op(8'h02, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "small_diff");
        run_op(8'hFE, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "swap");
        run_op(8'h28, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "saturate");
        run_op(8'h80, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "neg_sat");
        run_op(8'h05, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lead_zeros3");
        run_op(8'h01, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "carry");
        run_op(8'h00, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "round_renorm");
        run_op(8'h00, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "zero_sum");
        run_op(8'h19, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "tie_even");
    endtask

    task automatic test_abort();
        @(negedge clk);
        bus.diferenca_exp = 8'h03; bus.exp_A_ge_B = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got %h want 0", all_outs());
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet(n=%0d): got done=%b busy=%b want 0 0",
                         n, bus.done, bus.busy);
            end
        end
        run_op(8'h04, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_op(8'($urandom_range(0, 255)), 1'($urandom), 1'($urandom),
                   8'($urandom_range(0, 24)), 1'($urandom_range(0, 4) == 0),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uc_soma.md
UC_SOMA -- requirements
Module: uc_soma

Interface
REQ-001 Parameters SHALL be: N_float, 32, float width; N_exp, 8, exponent width; N_mant, 23, mantissa width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 diferenca_exp  input  N_exp  exp_A-exp_B mod 2^N_exp, from the small ALU.
REQ-006 exp_A_ge_B  input  1  small-ALU carry-out; 1 = exp_A >= exp_B.
REQ-007 sum_carry  input  1  big-ALU sum bit N_mant+1.
REQ-008 lead_zeros  input  N_exp  leading-zero count of the big-ALU sum, bits N_mant..0.
REQ-009 sum_zero  input  1  big-ALU sum equals zero.
REQ-010 lsb, guard, sticky  input  1 each  rounding bits of the normalized mantissa.
REQ-011 round_carry  input  1  rounding increment overflowed the mantissa.
REQ-012 BigAlu_in_A, BigAlu_in_B  output  1 each  big-ALU operand selects: BigAlu_in_A=swap, BigAlu_in_B=~swap.
REQ-013 ShiftDif_amount  output  N_exp  alignment right-shift amount.
REQ-014 Exp_sel  output  1  result-exponent mux select (=swap).
REQ-015 ShiftNorm_sel, ShiftNorm_amount  output  1, N_exp  normalize direction (0 = right, 1 = left) and distance.
REQ-016 Increment_sel, Increment_amount  output  1, N_exp  exponent adjust (0 = increment, 1 = decrement) and amount.
REQ-017 Round_amount  output  1  add one ulp.
REQ-018 busy, done, result_zero  output  1 each  operation in progress, one-cycle completion pulse, zero result.

Function
REQ-019 The FSM SHALL use states IDLE, ALIGN, ADD, NORM, ROUND, RENORM, DONE; all outputs SHALL be registered (Moore).
REQ-020 In IDLE with start=1, the block SHALL latch swap=~exp_A_ge_B and mag = exp_A_ge_B ? diferenca_exp : (-diferenca_exp mod 2^N_exp), then enter ALIGN.
REQ-021 ShiftDif_amount SHALL equal min(mag, N_mant+2) and, together with BigAlu_in_A/B and Exp_sel, SHALL hold from ALIGN through DONE.
REQ-022 The FSM SHALL go ALIGN->ADD->NORM unconditionally, one cycle each.
REQ-023 In NORM: if sum_zero=1, result_zero=1 and the next state is DONE; else if sum_carry=1, ShiftNorm_sel=0, ShiftNorm_amount=1, Increment_sel=0, Increment_amount=1; else ShiftNorm_sel=1, ShiftNorm_amount=lead_zeros, Increment_sel=1, Increment_amount=lead_zeros; otherwise the next state is ROUND.
REQ-024 In ROUND: Round_amount = guard & (sticky | lsb) (nearest-even); if round_carry=1 the next state is RENORM, else DONE.
REQ-025 RENORM SHALL apply right shift 1 and increment 1, then go to DONE; it runs at most once per operation.
REQ-026 DONE SHALL pulse done=1 for exactly one cycle, then return to IDLE; start in DONE SHALL be ignored.
REQ-027 Latency from the start edge to done high SHALL be 5 cycles, 6 with RENORM, 4 on a zero result.
REQ-028 busy SHALL be 1 in every state except IDLE; result_zero SHALL hold until the next accepted start.
REQ-029 Outside their active state, Round_amount, ShiftNorm_amount and Increment_amount SHALL be 0.

Reset
REQ-030 rst_n=0 SHALL force IDLE and every output to 0 immediately, including mid-operation; an aborted operation SHALL produce no done.

Configuration
REQ-031 With SOMA_ROUND_EN defined, ROUND and RENORM SHALL behave per REQ-024/025.
REQ-032 Without SOMA_ROUND_EN, the block SHALL truncate: NORM SHALL go to DONE, Round_amount SHALL be tied 0, and latency SHALL be 4 cycles.

Structure
REQ-033 Package soma_pkg SHALL hold the state enum, the default N_exp/N_mant values and the constant SHIFT_SAT = N_mant+2.
REQ-034 Sub-module soma_dif_mag SHALL compute the negate/saturate of REQ-020/021 combinationally.

Verification
REQ-035 diferenca_exp=0x02, exp_A_ge_B=1, start -> swap=0, ShiftDif_amount=2, done 5 cycles later.
REQ-036 diferenca_exp=0xFE, exp_A_ge_B=0 -> BigAlu_in_A=1, Exp_sel=1, ShiftDif_amount=2.
REQ-037 diferenca_exp=0x28, exp_A_ge_B=1 -> ShiftDif_amount=25 (saturated).
REQ-038 NORM with lead_zeros=3, sum_carry=0 -> ShiftNorm_sel=1, ShiftNorm_amount=3, Increment_sel=1, Increment_amount=3.
REQ-039 guard=1, sticky=0, lsb=1, round_carry=1 -> Round_amount=1, RENORM visited, done at cycle 6.
REQ-040 rst_n low during ADD -> all outputs 0 asynchronously, no done, next start accepted normally.
